keypad_code_ctrl: RTL

//  Access-code sequencer between the synchronized keypad nibble and the alarm core.
//  - Collects key presses into a code buffer and compares it with a stored code.
//  - Issues a one-cycle arm/disarm toggle command on a correct code.
//  - Counts consecutive failures and enforces a timed lockout.
//  - All timers advance only on the ENA tick from the top-level clock divider.

---
 rtl/keypad_code_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/keypad_code_ctrl.sv
// Access-code sequencer: collects keypad digits, checks them against a stored
// code, pulses arm_toggle on a match and enforces a timed lockout after
// repeated failures. All timers count ENA ticks from the top-level divider.
module keypad_code_ctrl #(
  parameter int unsigned            CODE_LEN  = 4,
  parameter logic [4*CODE_LEN-1:0]  CODE      = 16'h1234,
  parameter int unsigned            TIMEOUT_T = 20,
  parameter int unsigned            MAX_FAIL  = 3,
  parameter int unsigned            LOCK_T    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic [3:0] keypad,
  output logic       arm_toggle,
  output logic       code_err,
  output logic       locked,
  output logic       entry_active,
  output logic [2:0] digit_cnt
);

  localparam int unsigned BUF_W   = 4 * CODE_LEN;
  localparam int unsigned TMR_MAX = (TIMEOUT_T > LOCK_T) ? TIMEOUT_T : LOCK_T;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned FAIL_W  = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;

  logic [1:0]        state, state_n;
  logic [3:0]        keypad_q;
  logic [BUF_W-1:0]  code_buf, buf_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [FAIL_W-1:0] fail_cnt, fail_n, fail_inc;
  logic [TMR_W-1:0]  tmr, tmr_n;
  logic              arm_n, err_n;
  logic [2:0]        digit_cnt_n;
  logic              press_c, digit_c, clear_c, enter_c, match_c;

  // Release-to-press edge detect and key classification
  always_comb begin
    press_c  = (keypad != 4'h0) && (keypad_q == 4'h0);
    digit_c  = press_c && (keypad <= 4'hD);
    clear_c  = press_c && (keypad == 4'hE);
    enter_c  = press_c && (keypad == 4'hF);
    match_c  = (cnt == CNT_W'(CODE_LEN)) && (code_buf == CODE);
    fail_inc = fail_cnt + FAIL_W'(1);
  end

  // Next-state, buffer, counters and pulse decode
  always_comb begin
    state_n = state;
    buf_n   = code_buf;
    cnt_n   = cnt;
    fail_n  = fail_cnt;
    tmr_n   = tmr;
    arm_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        tmr_n = '0;
        if (digit_c) begin
          buf_n   = BUF_W'(keypad);
          cnt_n   = CNT_W'(1);
          state_n = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (digit_c) begin
          if (cnt <= CNT_W'(CODE_LEN)) begin
            buf_n = BUF_W'({code_buf, keypad});
            cnt_n = cnt + CNT_W'(1);
          end
          tmr_n = '0;
        end else if (clear_c) begin
          buf_n   = '0;
          cnt_n   = '0;
          tmr_n   = '0;
          state_n = S_IDLE;
        end else if (enter_c) begin
          buf_n = '0;
          cnt_n = '0;
          tmr_n = '0;
          if (match_c) begin
            arm_n   = 1'b1;
            fail_n  = '0;
            state_n = S_IDLE;
          end else begin
            err_n = 1'b1;
            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
              fail_n  = '0;
              state_n = S_LOCK;
            end else begin
              fail_n  = fail_inc;
              state_n = S_IDLE;
            end
          end
        end else if (ENA) begin
          if (tmr == TMR_W'(TIMEOUT_T - 1)) begin
            buf_n   = '0;
            cnt_n   = '0;
            tmr_n   = '0;
            state_n = S_IDLE;
          end else begin
            tmr_n = tmr + TMR_W'(1);
          end
        end
      end
      S_LOCK: begin
        if (ENA) begin
          if (tmr == TMR_W'(LOCK_T - 1)) begin
            tmr_n   = '0;
            state_n = S_IDLE;
          end else begin
            tmr_n = tmr + TMR_W'(1);
          end
        end
      end
      default: begin
        buf_n   = '0;
        cnt_n   = '0;
        fail_n  = '0;
        tmr_n   = '0;
        state_n = S_IDLE;
      end
    endcase
    digit_cnt_n = (cnt_n > CNT_W'(7)) ? 3'd7 : cnt_n[2:0];
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      keypad_q     <= 4'h0;
      code_buf     <= '0;
      cnt          <= '0;
      fail_cnt     <= '0;
      tmr          <= '0;
      arm_toggle   <= 1'b0;
      code_err     <= 1'b0;
      locked       <= 1'b0;
      entry_active <= 1'b0;
      digit_cnt    <= 3'd0;
    end else begin
      state        <= state_n;
      keypad_q     <= keypad;
      code_buf     <= buf_n;
      cnt          <= cnt_n;
      fail_cnt     <= fail_n;
      tmr          <= tmr_n;
      arm_toggle   <= arm_n;
      code_err     <= err_n;
      locked       <= (state_n == S_LOCK);
      entry_active <= (state_n == S_ENTRY);
      digit_cnt    <= digit_cnt_n;
    end
  end

endmodule
